irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_7F20, byte base address of the 5-word register window.
REQ-002 SHALL have parameter NSRC, default 6, number of interrupt sources, legal range 1..8.
REQ-003 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port irq_in  input  NSRC  raw source lines, synchronous to clk: timer0, timer1, external, others tied 0.
REQ-006 SHALL have port Addr  input  30  word address, byte address bits [31:2], from the bridge.
REQ-007 SHALL have port WE  input  1  write strobe, already decoded for this window by the bridge.
REQ-008 SHALL have port Din  input  32  write data.
REQ-009 SHALL have port Dout  output  32  combinational read data for Addr.
REQ-010 SHALL have port HWInt  output  NSRC  eligible-interrupt vector to CP0.

Function
REQ-011 SHALL implement these registers at BASE offsets: 0x00 PEND (read, write-1-to-clear), 0x04 MASK (RW), 0x08 MODE (RW; bit=1 edge, 0 level), 0x0C INSV (read; write-1-to-clear = EOI), 0x10 CLAIM.
REQ-012 SHALL return 0 on Dout for unmapped offsets; writes to them SHALL be ignored.
REQ-013 SHALL implement only bits [NSRC-1:0] in each register; upper read bits SHALL be 0.
REQ-014 SHALL hold a prev register of irq_in and detect a rising edge as irq_in & ~prev.
REQ-015 Edge-mode source: SHALL set PEND on a detected edge and clear it by PEND W1C or by CLAIM.
REQ-016 Edge-mode source: when an edge and a clear happen in the same cycle, the set SHALL win.
REQ-017 Level-mode source: PEND bit SHALL equal the registered irq_in level; W1C to PEND SHALL have no effect.
REQ-018 Priority: a lower source index SHALL have higher priority.
REQ-019 Let top = the highest-priority INSV bit. HWInt[i] SHALL be PEND[i] & MASK[i] & (i has higher priority than top, or INSV==0).
REQ-020 Latency: an edge sampled at cycle n SHALL set PEND at the end of cycle n, and HWInt SHALL assert in cycle n+1, combinationally from registers.
REQ-021 CLAIM read SHALL return {bit31 = |HWInt, bits[2:0] = index of highest-priority HWInt bit}; it SHALL return 0 when HWInt is 0, and the read SHALL have no side effect.
REQ-022 CLAIM write with id = Din[2:0] < NSRC SHALL set INSV[id] and clear PEND[id] if edge-mode; it SHALL be ignored if id >= NSRC.
REQ-023 A CLAIM write and an EOI to the same bit in the same cycle SHALL leave the INSV bit set.
REQ-024 A MODE change SHALL take effect next cycle; switching edge->level SHALL overwrite PEND with the level.
REQ-025 MASK SHALL gate only HWInt; masked sources SHALL still latch PEND.

Reset
REQ-026 Asserting reset SHALL asynchronously clear PEND, MASK, MODE, INSV and prev to 0, so HWInt = 0.
REQ-027 Reset asserted mid-service SHALL discard all in-service state; edges during reset SHALL be lost.
REQ-028 A source high at reset release SHALL not be seen as an edge in the first cycle (prev takes the reset value 0, so an edge IS seen; required: prev SHALL load irq_in on the first post-reset cycle before edge detection is enabled).

Structure
REQ-029 Register offsets, BASE and the CLAIM field layout SHALL be defined in the shared macros header next to the existing device address map.
REQ-030 The highest-set-bit logic SHALL be one sub-module, irq_prio_enc, instanced twice: once for HWInt and once for INSV.
REQ-031 The bridge SHALL gain one address window and one WE decode; the CPU and TC blocks SHALL be unchanged.

Verification
REQ-032 MODE=0x3, MASK=0x3; pulse irq_in[1] for 1 cycle -> PEND=0x2 and HWInt=0x02 next cycle; CLAIM read = 0x8000_0001.
REQ-033 PEND bits 0 and 1 both set; write CLAIM=1 -> INSV=0x2 and HWInt=0x01 (bit 0 preempts); write CLAIM=0 -> INSV=0x3 and HWInt=0.
REQ-034 INSV=0x1 with PEND[2] set -> HWInt=0; write EOI INSV=0x1 -> HWInt=0x04 the next cycle.
REQ-035 Edge on source 0 in the same cycle as PEND W1C 0x1 -> PEND[0]=1 afterwards.
REQ-036 Level mode: hold irq_in[2]=1 with MASK=0 -> PEND=0x4 and HWInt=0; set MASK=0x4 -> HWInt=0x04; drop the level -> HWInt=0 one cycle later.
REQ-037 Assert reset asynchronously mid-service (INSV=0x2) -> all registers 0 and HWInt=0 immediately; CLAIM write id=7 -> ignored.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, default window
// base and CLAIM word layout.
package irq_ctrl_pkg;

  // Word index of each register relative to the window base.
  typedef enum logic [2:0] {
    REG_PEND  = 3'd0,
    REG_MASK  = 3'd1,
    REG_MODE  = 3'd2,
    REG_INSV  = 3'd3,
    REG_CLAIM = 3'd4
  } reg_sel_e;

  localparam logic [31:0] IRQ_BASE_DEFAULT = 32'h0000_7F20;
  localparam int          NUM_REGS         = 5;
  localparam int          CLAIM_VLD_BIT    = 31;
  localparam int          CLAIM_ID_W       = 3;

  function automatic logic [31:0] claim_word(input logic vld,
                                             input logic [CLAIM_ID_W-1:0] id);
    claim_word                   = '0;
    claim_word[CLAIM_VLD_BIT]    = vld;
    claim_word[CLAIM_ID_W-1:0]   = id;
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Priority encoder: reports whether any bit is set and the index of the
// highest-priority (lowest-numbered) set bit.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 6
) (
  input  logic [N-1:0]            vec,
  output logic                    any,
  output logic [CLAIM_ID_W-1:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = CLAIM_ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/mode/in-service registers,
// fixed priority with in-service preemption, and a CLAIM register for dispatch.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE = IRQ_BASE_DEFAULT,
  parameter int          NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [29:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  output logic [NSRC-1:0] HWInt
);

  logic [NSRC-1:0] pend, mask, mode, insv, prev;
  logic            armed;

  logic [29:0]     word_off;
  logic            in_win;
  reg_sel_e        sel;
  logic            wr_pend, wr_mask, wr_mode, wr_insv, wr_claim;

  logic [CLAIM_ID_W-1:0] claim_id;
  logic                  claim_ok;
  logic [NSRC-1:0]       claim_set, w1c, eoi, edge_det;
  logic [NSRC-1:0]       pend_next, insv_next, elig;

  logic                  insv_any, hw_any;
  logic [CLAIM_ID_W-1:0] insv_top, hw_idx;
  logic                  unused_din;

  assign word_off = Addr - BASE[31:2];
  assign in_win   = word_off < 30'(NUM_REGS);
  assign sel      = reg_sel_e'(word_off[2:0]);

  assign wr_pend  = WE && in_win && (sel == REG_PEND);
  assign wr_mask  = WE && in_win && (sel == REG_MASK);
  assign wr_mode  = WE && in_win && (sel == REG_MODE);
  assign wr_insv  = WE && in_win && (sel == REG_INSV);
  assign wr_claim = WE && in_win && (sel == REG_CLAIM);

  assign claim_id  = Din[CLAIM_ID_W-1:0];
  assign claim_ok  = wr_claim && ({29'd0, claim_id} < 32'(NSRC));
  assign claim_set = claim_ok ? (NSRC'(1) << claim_id) : '0;
  assign w1c       = wr_pend ? Din[NSRC-1:0] : '0;
  assign eoi       = wr_insv ? Din[NSRC-1:0] : '0;
  assign unused_din = ^Din[31:NSRC];

  // Edge detection stays off until prev has captured the live lines once after reset.
  assign edge_det  = irq_in & ~prev & {NSRC{armed}};

  // Edge sources: a new edge beats any clear. Level sources follow the line.
  assign pend_next = (mode & (edge_det | (pend & ~(w1c | claim_set))))
                   | (~mode & irq_in);
  // A claim in the same cycle as an EOI leaves the source in service.
  assign insv_next = (insv & ~eoi) | claim_set;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend  <= '0;
      mask  <= '0;
      mode  <= '0;
      insv  <= '0;
      prev  <= '0;
      armed <= 1'b0;
    end else begin
      pend  <= pend_next;
      insv  <= insv_next;
      prev  <= irq_in;
      armed <= 1'b1;
      if (wr_mask) mask <= Din[NSRC-1:0];
      if (wr_mode) mode <= Din[NSRC-1:0];
    end
  end

  irq_prio_enc #(.N(NSRC)) u_insv_enc (
    .vec (insv),
    .any (insv_any),
    .idx (insv_top)
  );

  // Only sources strictly more urgent than the one in service may interrupt.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NSRC; i++) begin
      elig[i] = !insv_any || (CLAIM_ID_W'(i) < insv_top);
    end
  end

  assign HWInt = pend & mask & elig;

  irq_prio_enc #(.N(NSRC)) u_hw_enc (
    .vec (HWInt),
    .any (hw_any),
    .idx (hw_idx)
  );

  always_comb begin
    Dout = '0;
    if (in_win) begin
      case (sel)
        REG_PEND:  Dout = 32'(pend);
        REG_MASK:  Dout = 32'(mask);
        REG_MODE:  Dout = 32'(mode);
        REG_INSV:  Dout = 32'(insv);
        REG_CLAIM: Dout = hw_any ? claim_word(1'b1, hw_idx) : '0;
        default:   Dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic against a rule-level reference model.
module tb_irq_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7F20;
  localparam int          NSRC = 6;
  localparam logic [7:0]  SRCM = 8'h3F;

  localparam logic [7:0] OFF_PEND  = 8'h00;
  localparam logic [7:0] OFF_MASK  = 8'h04;
  localparam logic [7:0] OFF_MODE  = 8'h08;
  localparam logic [7:0] OFF_INSV  = 8'h0C;
  localparam logic [7:0] OFF_CLAIM = 8'h10;
  localparam logic [7:0] OFF_UNMAP = 8'h14;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] irq_in = '0;
  logic [29:0]     Addr = '0;
  logic            WE = 1'b0;
  logic [31:0]     Din = '0;
  logic [31:0]     Dout;
  logic [NSRC-1:0] HWInt;

  int checks = 0;
  int errors = 0;

  // Reference model state, one bit per source.
  logic [7:0] m_pend, m_mask, m_mode, m_insv, m_prev;
  bit         m_armed;

  typedef struct {
    logic [NSRC-1:0] irq;
    bit              we;
    logic [7:0]      off;
    logic [31:0]     din;
    logic [7:0]      pend;
    logic [7:0]      insv;
    logic [7:0]      hw;
  } vec_t;

  vec_t tbl[16];

  irq_ctrl #(.BASE(BASE), .NSRC(NSRC)) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_in (irq_in),
    .Addr   (Addr),
    .WE     (WE),
    .Din    (Din),
    .Dout   (Dout),
    .HWInt  (HWInt)
  );

  always #10 clk = ~clk;

  function automatic logic [29:0] addr_of(input logic [7:0] off);
    logic [31:0] b;
    b = BASE + 32'(off);
    return b[31:2];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] claim_of(input logic [7:0] hw);
    for (int i = 0; i < 8; i++) begin
      if (hw[i]) return 32'h8000_0000 | 32'(i);
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_mode = '0; m_insv = '0; m_prev = '0;
    m_armed = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] irq, input bit we,
                            input logic [7:0] off, input logic [31:0] din);
    logic [7:0] np, ni;
    int         id;
    bit         claim_ok, edge_seen, cleared;
    np = '0;
    ni = '0;
    id = int'(din[2:0]);
    claim_ok = we && (off == OFF_CLAIM) && (id < NSRC);
    for (int i = 0; i < NSRC; i++) begin
      edge_seen = m_armed && irq[i] && !m_prev[i];
      cleared   = (we && off == OFF_PEND && din[i]) || (claim_ok && id == i);
      if (!m_mode[i])     np[i] = irq[i];
      else if (edge_seen) np[i] = 1'b1;
      else if (cleared)   np[i] = 1'b0;
      else                np[i] = m_pend[i];
      if (claim_ok && id == i)                 ni[i] = 1'b1;
      else if (we && off == OFF_INSV && din[i]) ni[i] = 1'b0;
      else                                     ni[i] = m_insv[i];
    end
    if (we && off == OFF_MASK) m_mask = din[7:0] & SRCM;
    if (we && off == OFF_MODE) m_mode = din[7:0] & SRCM;
    m_pend  = np;
    m_insv  = ni;
    m_prev  = irq & SRCM;
    m_armed = 1'b1;
  endtask

  function automatic logic [7:0] model_hw();
    int         top;
    logic [7:0] hw;
    top = NSRC;
    for (int i = NSRC - 1; i >= 0; i--) if (m_insv[i]) top = i;
    hw = '0;
    for (int i = 0; i < top; i++) hw[i] = m_pend[i] & m_mask[i];
    return hw;
  endfunction

  task automatic rd(input logic [7:0] off, output logic [31:0] val);
    Addr = addr_of(off);
    #1;
    val = Dout;
  endtask

  // One clock with the given inputs; the model sees the same inputs.
  task automatic cycle(input logic [NSRC-1:0] irq, input bit we,
                       input logic [7:0] off, input logic [31:0] din);
    irq_in = irq;
    WE     = we;
    Addr   = addr_of(off);
    Din    = din;
    model_step(8'(irq), we, off, din);
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] v;
    logic [7:0]  hw;
    hw = model_hw();
    chk({tag, " hwint"}, 32'(HWInt), 32'(hw));
    rd(OFF_PEND, v);  chk({tag, " pend"}, v, 32'(m_pend));
    rd(OFF_MASK, v);  chk({tag, " mask"}, v, 32'(m_mask));
    rd(OFF_MODE, v);  chk({tag, " mode"}, v, 32'(m_mode));
    rd(OFF_INSV, v);  chk({tag, " insv"}, v, 32'(m_insv));
    rd(OFF_CLAIM, v); chk({tag, " claim"}, v, claim_of(hw));
    rd(OFF_UNMAP, v); chk({tag, " unmapped"}, v, 32'h0);
  endtask

  task automatic check_zero(input string tag);
    logic [31:0] v;
    chk({tag, " hwint"}, 32'(HWInt), 32'h0);
    rd(OFF_PEND, v);  chk({tag, " pend"}, v, 32'h0);
    rd(OFF_MASK, v);  chk({tag, " mask"}, v, 32'h0);
    rd(OFF_MODE, v);  chk({tag, " mode"}, v, 32'h0);
    rd(OFF_INSV, v);  chk({tag, " insv"}, v, 32'h0);
    rd(OFF_CLAIM, v); chk({tag, " claim"}, v, 32'h0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    irq_in = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle('0, 1'b0, OFF_UNMAP, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    model_reset();

    tbl[0]  = '{6'h00, 1'b1, OFF_MODE,  32'h3,         8'h0, 8'h0, 8'h0};
    tbl[1]  = '{6'h00, 1'b1, OFF_MASK,  32'h3,         8'h0, 8'h0, 8'h0};
    tbl[2]  = '{6'h02, 1'b0, OFF_UNMAP, 32'h0,         8'h2, 8'h0, 8'h2};
    tbl[3]  = '{6'h00, 1'b0, OFF_UNMAP, 32'h0,         8'h2, 8'h0, 8'h2};
    tbl[4]  = '{6'h01, 1'b0, OFF_UNMAP, 32'h0,         8'h3, 8'h0, 8'h3};
    tbl[5]  = '{6'h00, 1'b1, OFF_CLAIM, 32'h1,         8'h1, 8'h2, 8'h1};
    tbl[6]  = '{6'h00, 1'b1, OFF_CLAIM, 32'h0,         8'h0, 8'h3, 8'h0};
    tbl[7]  = '{6'h00, 1'b1, OFF_INSV,  32'h2,         8'h0, 8'h1, 8'h0};
    tbl[8]  = '{6'h00, 1'b1, OFF_MASK,  32'h7,         8'h0, 8'h1, 8'h0};
    tbl[9]  = '{6'h00, 1'b1, OFF_MODE,  32'h7,         8'h0, 8'h1, 8'h0};
    tbl[10] = '{6'h04, 1'b0, OFF_UNMAP, 32'h0,         8'h4, 8'h1, 8'h0};
    tbl[11] = '{6'h00, 1'b1, OFF_INSV,  32'h1,         8'h4, 8'h0, 8'h4};
    tbl[12] = '{6'h01, 1'b1, OFF_PEND,  32'h1,         8'h5, 8'h0, 8'h5};
    tbl[13] = '{6'h00, 1'b1, OFF_PEND,  32'h5,         8'h0, 8'h0, 8'h0};
    tbl[14] = '{6'h00, 1'b1, OFF_UNMAP, 32'hFFFF_FFFF, 8'h0, 8'h0, 8'h0};
    tbl[15] = '{6'h00, 1'b1, OFF_CLAIM, 32'h7,         8'h0, 8'h0, 8'h0};

    // Reset state
    @(posedge clk);
    #1;
    check_zero("reset_state");
    reset = 1'b0;
    cycle('0, 1'b0, OFF_UNMAP, 32'h0);

    // Directed vector table
    for (int r = 0; r < 16; r++) begin
      cycle(tbl[r].irq, tbl[r].we, tbl[r].off, tbl[r].din);
      chk($sformatf("tbl%0d hwint", r), 32'(HWInt), 32'(tbl[r].hw));
      rd(OFF_PEND, v);  chk($sformatf("tbl%0d pend", r), v, 32'(tbl[r].pend));
      rd(OFF_INSV, v);  chk($sformatf("tbl%0d insv", r), v, 32'(tbl[r].insv));
      rd(OFF_CLAIM, v); chk($sformatf("tbl%0d claim", r), v, claim_of(tbl[r].hw));
    end
    rd(OFF_MASK, v); chk("unmapped write left mask", v, 32'h7);
    rd(OFF_MODE, v); chk("unmapped write left mode", v, 32'h7);

    // Level mode: PEND follows the line, MASK gates only HWInt, W1C ignored
    reset_dut();
    cycle(6'h04, 1'b0, OFF_UNMAP, 32'h0);
    rd(OFF_PEND, v); chk("level pend masked", v, 32'h4);
    chk("level hwint masked", 32'(HWInt), 32'h0);
    cycle(6'h04, 1'b1, OFF_MASK, 32'h4);
    chk("level hwint unmasked", 32'(HWInt), 32'h4);
    cycle(6'h04, 1'b1, OFF_PEND, 32'h4);
    rd(OFF_PEND, v); chk("level w1c ignored", v, 32'h4);
    cycle(6'h00, 1'b0, OFF_UNMAP, 32'h0);
    chk("level drop hwint", 32'(HWInt), 32'h0);
    rd(OFF_PEND, v); chk("level drop pend", v, 32'h0);

    // Asynchronous reset in the middle of service
    cycle(6'h00, 1'b1, OFF_MODE, 32'h3);
    cycle(6'h00, 1'b1, OFF_MASK, 32'h3);
    cycle(6'h02, 1'b0, OFF_UNMAP, 32'h0);
    cycle(6'h00, 1'b1, OFF_CLAIM, 32'h1);
    rd(OFF_INSV, v); chk("mid-service insv", v, 32'h2);
    #2;
    reset = 1'b1;
    #1;
    check_zero("async_reset");
    for (int k = 0; k < 3; k++) begin
      irq_in = (k % 2 == 0) ? 6'h3F : 6'h00;
      @(posedge clk);
      #1;
    end
    chk("reset held hwint", 32'(HWInt), 32'h0);
    irq_in = '0;
    reset  = 1'b0;
    model_reset();
    cycle('0, 1'b0, OFF_UNMAP, 32'h0);
    rd(OFF_PEND, v); chk("edges lost during reset", v, 32'h0);
    cycle('0, 1'b1, OFF_CLAIM, 32'h7);
    rd(OFF_INSV, v); chk("claim id7 ignored", v, 32'h0);

    // Source held high across reset release is not an edge
    reset = 1'b1;
    irq_in = 6'h01;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    cycle(6'h01, 1'b0, OFF_UNMAP, 32'h0);
    cycle(6'h01, 1'b1, OFF_MODE, 32'h1);
    cycle(6'h01, 1'b1, OFF_PEND, 32'h1);
    cycle(6'h01, 1'b0, OFF_UNMAP, 32'h0);
    rd(OFF_PEND, v); chk("held line no edge", v, 32'h0);
    check_model("held_line");

    // Randomized traffic against the reference model
    reset_dut();
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [7:0]  off;
      logic [31:0] din;
      bit          we;
      r   = $urandom_range(0, 9);
      we  = (r <= 5);
      off = we ? 8'(r * 4) : OFF_UNMAP;
      din = $urandom;
      if (off == OFF_CLAIM) din = 32'($urandom_range(0, 7));
      if (off == OFF_INSV || off == OFF_PEND) din = din & $urandom;
      cycle(6'($urandom), we, off, din);
      check_model($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
